uart_rx_frame: RTL and testbench

//  Receive side of the UART link: recovers start/data/parity/stop frames from the serial line
//  and presents parallel bytes. Frame format matches the TX path:
//  - idle high, 1 start bit (0), Data_Width data bits LSB first;
//  - optional parity bit, then 1 stop bit (1).

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_frame_if.sv | 26 ++
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx_frame.sv | 151 +++++++++++++++
 tb/tb_uart_rx_frame.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity-type codes
// used by both the RX frame decoder and the TX parity unit.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial-in / parallel-out bundle of the UART receiver.
// master drives the line and frame config, slave is the receiver.
interface uart_rx_frame_if #(
   parameter int Data_Width = 8
);
   logic                  RX_In;
   logic                  Par_En;
   logic                  Par_Type;
   logic [Data_Width-1:0] P_Data;
   logic                  Data_Valid;
   logic                  Par_Err;
   logic                  Stop_Err;
   logic                  Busy;

   modport master (
      output RX_In, Par_En, Par_Type,
      input  P_Data, Data_Valid, Par_Err,
      input  Stop_Err, Busy
   );

   modport slave (
      input  RX_In, Par_En, Par_Type,
      output P_Data, Data_Valid, Par_Err,
      output Stop_Err, Busy
   );
endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timer and sample point for the UART receiver.
// UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decision 1 clk later.
module uart_rx_sampler #(
   parameter int Prescale = 8
) (
   input  logic clk,
   input  logic RST,
   input  logic rx_s_i,
   input  logic start_i,
   input  logic run_i,
   output logic sample_valid_o,
   output logic sample_bit_o,
   output logic bit_end_o
);
   localparam int CW = $clog2(Prescale);
   localparam logic [CW-1:0] ONE  = CW'(1);
   localparam logic [CW-1:0] MID  = CW'(Prescale / 2);
   localparam logic [CW-1:0] LAST = CW'(Prescale - 1);

   logic [CW-1:0] bit_cnt_q, bit_cnt_d;

   // restart on start detect, free-run and wrap while a frame is active
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      if (start_i) begin
         bit_cnt_d = '0;
      end else if (run_i) begin
         if (bit_cnt_q == LAST) bit_cnt_d = '0;
         else                   bit_cnt_d = bit_cnt_q + ONE;
      end
   end

   // bit counter register
   always_ff @(posedge clk) begin
      if (RST) bit_cnt_q <= '0;
      else     bit_cnt_q <= bit_cnt_d;
   end

   assign bit_end_o = run_i && (bit_cnt_q == LAST);

`ifdef UART_RX_MAJORITY_EN
   logic early_q, mid_q;

   // hold the two samples that precede the voting point
   always_ff @(posedge clk) begin
      if (RST) begin
         early_q <= 1'b1;
         mid_q   <= 1'b1;
      end else begin
         if (run_i && bit_cnt_q == MID - ONE) early_q <= rx_s_i;
         if (run_i && bit_cnt_q == MID)       mid_q   <= rx_s_i;
      end
   end

   assign sample_valid_o = run_i && (bit_cnt_q == MID + ONE);
   assign sample_bit_o   = (early_q & mid_q) |
                           (early_q & rx_s_i) |
                           (mid_q & rx_s_i);
`else
   assign sample_valid_o = run_i && (bit_cnt_q == MID);
   assign sample_bit_o   = rx_s_i;
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start/data/parity/stop decode with error flags.
// Optional UART_RX_MAJORITY_EN selects majority-vote bit sampling.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int Data_Width = 8,
   parameter int Prescale   = 8
) (
   input logic            clk,
   input logic            RST,
   uart_rx_frame_if.slave bus
);
   localparam int NW = $clog2(Data_Width + 1);
   localparam logic [NW-1:0] NONE = NW'(1);
   localparam logic [NW-1:0] NALL = NW'(Data_Width);

   rx_state_e state_q, state_d;
   logic rx_s1_q, rx_s_q;
   logic [Data_Width-1:0] shift_q, shift_d;
   logic [Data_Width-1:0] p_data_q, p_data_d;
   logic [NW-1:0] n_q, n_d;
   logic par_en_q, par_en_d;
   logic par_type_q, par_type_d;
   logic par_bad_q, par_bad_d;
   logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
   logic busy_q, busy_d;
   logic start_det, run;
   logic samp_v, samp_b, bit_end;

   assign run = (state_q != IDLE);

   uart_rx_sampler #(
      .Prescale(Prescale)
   ) u_sampler (
      .clk           (clk),
      .RST           (RST),
      .rx_s_i        (rx_s_q),
      .start_i       (start_det),
      .run_i         (run),
      .sample_valid_o(samp_v),
      .sample_bit_o  (samp_b),
      .bit_end_o     (bit_end)
   );

   // two-flop synchronizer for the asynchronous line
   always_ff @(posedge clk) begin
      if (RST) begin
         rx_s1_q <= 1'b1;
         rx_s_q  <= 1'b1;
      end else begin
         rx_s1_q <= bus.RX_In;
         rx_s_q  <= rx_s1_q;
      end
   end

   // frame FSM, shift register and one-cycle outcome decision
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      p_data_d   = p_data_q;
      n_d        = n_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      par_bad_d  = par_bad_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;
      start_det  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d    = START;
               start_det  = 1'b1;
               par_en_d   = bus.Par_En;
               par_type_d = bus.Par_Type;
               par_bad_d  = 1'b0;
               n_d        = '0;
            end
         end
         START: begin
            if (samp_v && samp_b) state_d = IDLE;
            else if (bit_end)     state_d = DATA;
         end
         DATA: begin
            if (samp_v) begin
               shift_d = {samp_b, shift_q[Data_Width-1:1]};
               n_d     = n_q + NONE;
            end
            if (bit_end && n_q == NALL)
               state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (samp_v)
               par_bad_d = samp_b ^ (^shift_q) ^
                           (par_type_q == PAR_ODD);
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            if (samp_v) begin
               state_d = IDLE;
               if (!samp_b) begin
                  se_d = 1'b1;
               end else if (par_bad_q) begin
                  pe_d = 1'b1;
               end else begin
                  dv_d     = 1'b1;
                  p_data_d = shift_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         p_data_q   <= '0;
         n_q        <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= PAR_EVEN;
         par_bad_q  <= 1'b0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         p_data_q   <= p_data_d;
         n_q        <= n_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         par_bad_q  <= par_bad_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.P_Data     = p_data_q;
   assign bus.Data_Valid = dv_q;
   assign bus.Par_Err    = pe_q;
   assign bus.Stop_Err   = se_q;
   assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed frames plus random traffic,
// expected outcomes computed from the frame contents.
`timescale 1ns/1ps
module tb_uart_rx_frame;
   localparam int DW = 8;
   localparam int PS = 8;
   localparam logic [2:0] K_GOOD = 3'b001;
   localparam logic [2:0] K_PERR = 3'b010;
   localparam logic [2:0] K_SERR = 3'b100;

   typedef struct {
      logic [2:0]    kind;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic RST = 1'b1;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   logic [DW-1:0] last_good = '0;

   always #5 clk = ~clk;

   uart_rx_frame_if #(.Data_Width(DW)) bus ();

   uart_rx_frame #(
      .Data_Width(DW),
      .Prescale  (PS)
   ) dut (
      .clk(clk),
      .RST(RST),
      .bus(bus)
   );

   task automatic chk(input string name,
                      input logic [31:0] got,
                      input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h req=%0h", name, got, req);
      end
   endtask

   // monitor: every outcome pulse is matched against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      logic [2:0] k;
      k = {bus.Stop_Err, bus.Par_Err, bus.Data_Valid};
      if (!RST && k != 3'b000) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse got=%b data=%0h req=none",
                     k, bus.P_Data);
         end else begin
            e = q.pop_front();
            if (k !== e.kind || bus.P_Data !== e.data) begin
               bad++;
               $display("FAIL outcome got=%b/%0h req=%b/%0h",
                        k, bus.P_Data, e.kind, e.data);
            end
         end
      end
   end

   task automatic idle(input int n);
      bus.RX_In = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input logic glitch);
      for (int j = 0; j < PS; j++) begin
         bus.RX_In = (glitch && j == PS / 2 + 1) ? 1'b0 : b;
         @(negedge clk);
      end
   endtask

   // d: bits on the line, expd: word the receiver should deliver
   task automatic send_frame(input logic [DW-1:0] d,
                             input logic pen,
                             input logic pt,
                             input logic bad_par,
                             input logic stop,
                             input int gbit,
                             input logic scramble,
                             input logic [DW-1:0] expd);
      logic pbit;
      exp_t e;
      bus.Par_En   = pen;
      bus.Par_Type = pt;
      pbit = logic'(($countones(d) + int'(pt)) % 2) ^ bad_par;
      if (!stop) begin
         e.kind = K_SERR;
         e.data = last_good;
      end else if (pen && bad_par) begin
         e.kind = K_PERR;
         e.data = last_good;
      end else begin
         e.kind = K_GOOD;
         e.data = expd;
         last_good = expd;
      end
      q.push_back(e);
      drive_bit(1'b0, 1'b0);
      if (scramble) begin
         bus.Par_En   = 1'($urandom);
         bus.Par_Type = 1'($urandom);
      end
      for (int i = 0; i < DW; i++) drive_bit(d[i], gbit == i);
      if (pen) drive_bit(pbit, 1'b0);
      drive_bit(stop, 1'b0);
      bus.RX_In = 1'b1;
   endtask

   initial begin
      logic seen;
      logic [DW-1:0] d, gexp;
      logic pen, pt, bp, st;
      int gap;
      bus.RX_In    = 1'b1;
      bus.Par_En   = 1'b0;
      bus.Par_Type = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pdata", 32'(bus.P_Data), 0);
      chk("rst_dv", 32'(bus.Data_Valid), 0);
      chk("rst_pe", 32'(bus.Par_Err), 0);
      chk("rst_se", 32'(bus.Stop_Err), 0);
      chk("rst_busy", 32'(bus.Busy), 0);
      RST = 1'b0;
      idle(10);

      send_frame(8'hA5, 0, 0, 0, 1, -1, 0, 8'hA5);
      idle(16);
      chk("a5_pdata", 32'(bus.P_Data), 32'hA5);
      chk("a5_busy", 32'(bus.Busy), 0);

      send_frame(8'h3C, 1, 0, 0, 1, -1, 0, 8'h3C);
      idle(12);
      send_frame(8'h3C, 1, 0, 1, 1, -1, 0, 8'h3C);
      idle(16);
      chk("perr_hold", 32'(bus.P_Data), 32'h3C);

      send_frame(8'h7E, 1, 1, 0, 0, -1, 0, 8'h7E);
      send_frame(8'h11, 1, 1, 0, 1, -1, 0, 8'h11);
      idle(16);
      chk("b2b_pdata", 32'(bus.P_Data), 32'h11);

      bus.RX_In = 1'b0;
      repeat (3) @(negedge clk);
      bus.RX_In = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (bus.Busy) seen = 1'b1;
         @(negedge clk);
      end
      chk("glitch_busy", 32'(seen), 1);
      chk("glitch_idle", 32'(bus.Busy), 0);
      send_frame(8'h55, 0, 0, 0, 1, -1, 0, 8'h55);
      idle(16);
      chk("g55_pdata", 32'(bus.P_Data), 32'h55);

      d = 8'hC3;
      bus.Par_En = 1'b0;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
      for (int j = 0; j < 3; j++) begin
         bus.RX_In = d[4];
         @(negedge clk);
      end
      chk("mid_busy", 32'(bus.Busy), 1);
      RST = 1'b1;
      bus.RX_In = 1'b1;
      @(negedge clk);
      chk("mrst_pdata", 32'(bus.P_Data), 0);
      chk("mrst_dv", 32'(bus.Data_Valid), 0);
      chk("mrst_busy", 32'(bus.Busy), 0);
      RST = 1'b0;
      last_good = '0;
      idle(24);
      send_frame(8'h0F, 0, 0, 0, 1, -1, 0, 8'h0F);
      idle(16);
      chk("0f_pdata", 32'(bus.P_Data), 32'h0F);

`ifdef UART_RX_MAJORITY_EN
      gexp = 8'hFF;
`else
      gexp = 8'hFB;
`endif
      send_frame(8'hFF, 0, 0, 0, 1, 2, 0, gexp);
      idle(16);
      chk("ff_glitch", 32'(bus.P_Data), 32'(gexp));

      for (int n = 0; n < 40; n++) begin
         d   = DW'($urandom);
         pen = 1'($urandom);
         pt  = 1'($urandom);
         bp  = ($urandom % 4) == 0;
         st  = ($urandom % 6) != 0;
         send_frame(d, pen, pt, bp, st, -1, 1, d);
         if (!st) gap = ($urandom % 2) ? 0 : $urandom_range(20, 8);
         else     gap = $urandom_range(20, 0);
         idle(gap);
      end

      idle(40);
      chk("queue_empty", 32'(q.size()), 0);
      chk("end_busy", 32'(bus.Busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
